// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// The line is synchronised, sampled mid-bit by a single bit timer, and complete
// frames are pushed into the FIFO. A stop bit sampled low reports a frame error
// and parks the receiver until the line returns high.
module uart_rx_capture #(
  parameter int unsigned CYCLES_PER_BIT = 1736,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int unsigned TW = $clog2(CYCLES_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] HalfLoad  = TW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FullLoad  = TW'(CYCLES_PER_BIT - 1);
  localparam logic [AW:0]   CountFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e        r_state;
  logic          r_sync1, r_sync2;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overflow;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_rxd_s, w_tick, w_valid, w_pop, w_push_req, w_push, w_drop;

  assign w_rxd_s    = r_sync2;
  assign w_tick     = (r_timer == '0);
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && rx_ready;
  // A completed frame with a good stop bit offers a byte to the FIFO.
  assign w_push_req = (r_state == StStop) && w_tick && w_rxd_s;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push     = w_push_req && ((r_count != CountFull) || w_pop);
  assign w_drop     = w_push_req && !w_push;

  assign rx_valid  = w_valid;
  assign rx_count  = r_count;
  assign rx_data   = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: start detect, mid-bit sampling, stop check and break hold-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (!w_tick) r_timer <= r_timer - 1'b1;
      case (r_state)
        StIdle: begin
          if (!w_rxd_s) begin
            r_timer <= HalfLoad;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (!w_rxd_s) begin
              r_timer   <= FullLoad;
              r_bit_idx <= '0;
              r_state   <= StData;
            end else begin
              r_state <= StIdle;  // glitch shorter than half a bit
            end
          end
        end
        StData: begin
          if (w_tick) begin
            r_shift   <= {w_rxd_s, r_shift[7:1]};
            r_timer   <= FullLoad;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= StStop;
          end
        end
        StStop: begin
          if (w_tick) begin
            if (w_rxd_s) begin
              r_state <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StBreak;
            end
          end
        end
        StBreak: begin
          if (w_rxd_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Byte FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver for the chip_top debug UART, clocked by the system clock.
- Consumes the serial line driven by chip_top `txd`, or the board/bench line feeding `rxd`.
- Deserialises frames into bytes and buffers them in a first-word-fall-through FIFO with a valid/ready output.
- Also serves as the bench's console capture stage downstream of chip_top.

Parameters:
- CYCLES_PER_BIT, 1736: clk cycles per bit (200 MHz / 115200); legal minimum 8.
- FIFO_DEPTH, 16: byte FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle high.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte when rx_valid && rx_ready.
- rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overflow  out  1  sticky: a received byte was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset values, while rst=1 on a clock edge:
  - FSM goes to IDLE; FIFO is emptied.
  - rx_valid=0, rx_count=0, frame_err=0, overflow=0, rx_data=0.
  - Both synchroniser flops load 1.
- rxd passes through a 2-flop synchroniser (rxd_s). All FSM decisions use rxd_s.
- One bit-timer counter is used. "Tick" means the counter equals 0 in that cycle.
- IDLE: when rxd_s=0, load timer with CYCLES_PER_BIT/2-1 and go to START.
- START: on tick, sample rxd_s.
  - If 0: load timer CYCLES_PER_BIT-1, set bit_idx=0, go to DATA.
  - If 1: treat as a glitch; return to IDLE with no output.
- DATA: on each tick, shift rxd_s into the shift register LSB-first and reload the timer.
  - After the 8th sample (bit_idx=7), go to STOP.
- STOP: on tick, sample rxd_s.
  - If 1: push the byte and go to IDLE.
  - If 0: pulse frame_err for exactly 1 cycle (the cycle after the sample), discard the byte, go to BREAK.
- BREAK: stay until rxd_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Sampling point is mid-bit for the start, data and stop bits.
- Latency: the byte is visible (rx_valid=1, rx_data correct) on the cycle after the stop-bit tick.
- FIFO push rule:
  - The push is accepted if rx_count<FIFO_DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: push accepted, count unchanged).
  - Otherwise the byte is dropped and overflow is set the next cycle.
- FIFO pop: on rx_valid && rx_ready. rx_ready with the FIFO empty has no effect.
- rx_count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set and clear in the same cycle gives set (the set wins).
  - Once set, it holds until overflow_clr or rst.
- rx_data, rx_valid and rx_count come from registers only; there is no combinational path from rxd.
- Reset mid-frame: partial byte discarded, FIFO contents lost, FSM in IDLE the next cycle.
  - A line already low at reset release triggers a START check. If the line is still low mid-bit, the frame is received as normal.
- A new start bit may be detected the cycle after returning to IDLE (back-to-back frames with a 1-bit stop).

Test Plan:
- CYCLES_PER_BIT=16: send 0xA5 with a valid stop bit, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5; rx_count stays ≤1; frame_err=0.
- 3-cycle low glitch on rxd while idle → no rx_valid, no frame_err, FSM back in IDLE; a subsequent 0x3C is received correctly.
- Send 0x55 with stop bit=0, then hold rxd low for 40 cycles → one frame_err pulse, FIFO empty, no second frame until rxd returns high; next byte 0x81 received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05:
  - rx_count=4 and overflow=1.
  - Draining yields 0x01,0x02,0x03,0x04.
  - overflow_clr → overflow=0.
- FIFO full, pop the head with rx_ready=1 in the same cycle a 5th byte pushes → byte accepted, rx_count stays 4, overflow stays 0.
- Assert rst for 1 cycle mid-DATA of byte 0x7E with 2 bytes queued → rx_count=0, rx_valid=0 next cycle; the following full frame 0xC3 received correctly.
